// File: rtl/div_radix2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_radix2_pkg
//  Purpose  : Shared FSM encodings and DIV/DIVU ALU-control codes for the
//             EX-stage divider and the decoder.
//  Revision : 1.0  initial release
// ============================================================================
package div_radix2_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    // ALU-control codes follow the MIPS funct field so decode can pass it through.
    localparam logic [5:0] ALU_DIV  = 6'h1A;
    localparam logic [5:0] ALU_DIVU = 6'h1B;

    function automatic logic is_div_op(input logic [5:0] alu_ctrl);
        return (alu_ctrl == ALU_DIV) || (alu_ctrl == ALU_DIVU);
    endfunction

    function automatic logic is_signed_div(input logic [5:0] alu_ctrl);
        return alu_ctrl == ALU_DIV;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_radix2_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_radix2_if
//  Purpose  : EX-stage <-> divider bundle: launch/operands/annul in, stall,
//             ready pulse and {HI,LO} result out.
//  Revision : 1.0  initial release
// ============================================================================
interface div_radix2_if
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic               startE;
    logic               signedE;
    logic [WIDTH-1:0]   srcaE;
    logic [WIDTH-1:0]   srcbE;
    logic               annulE;
    logic               div_stallE;
    logic               div_readyE;
    logic [2*WIDTH-1:0] div_resultE;

    modport master (
        output startE, signedE, srcaE, srcbE, annulE,
        input  div_stallE, div_readyE, div_resultE
    );

    modport slave (
        input  startE, signedE, srcaE, srcbE, annulE,
        output div_stallE, div_readyE, div_resultE
    );
endinterface
`default_nettype wire

// File: rtl/div_radix2_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_radix2_step
//  Purpose  : One combinational restoring-division iteration on {rem,quo}.
//  Revision : 1.0  initial release
// ============================================================================
module div_radix2_step
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   rem_sel;
    logic             borrow;
    logic             unused_rem_top;

    // rem < divisor always, so the shifted remainder needs one extra bit
    // and the trial subtract is WIDTH+1 bits plus its borrow.
    assign rem_sh  = {rem, quo[WIDTH-1]};
    assign diff    = {1'b0, rem_sh} - {2'b00, divisor};
    assign borrow  = diff[WIDTH+1];
    assign rem_sel = borrow ? rem_sh : diff[WIDTH:0];

    assign rem_next       = rem_sel[WIDTH-1:0];
    assign quo_next       = {quo[WIDTH-2:0], ~borrow};
    // The selected remainder is always below the divisor, so its top bit is zero.
    assign unused_rem_top = rem_sel[WIDTH];

endmodule
`default_nettype wire

// File: rtl/div_radix2.sv
`default_nettype none
// ============================================================================
//  Module   : div_radix2
//  Purpose  : Multi-cycle radix-2 restoring divider for DIV/DIVU in EX;
//             returns {HI=remainder, LO=quotient} and stalls F/D/E meanwhile.
//  Revision : 1.0  initial release
// ============================================================================
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    div_radix2_if.slave  dif
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [1:0]         state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   rem_q,    rem_d;
    logic [WIDTH-1:0]   quo_q,    quo_d;
    logic [WIDTH-1:0]   dvsr_q,   dvsr_d;
    logic               sgn_q,    sgn_d;
    logic               qsign_q,  qsign_d;
    logic               rsign_q,  rsign_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   step_rem;
    logic [WIDTH-1:0]   step_quo;
    logic [WIDTH-1:0]   fix_rem;
    logic [WIDTH-1:0]   fix_quo;
    logic               kill;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    div_radix2_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvsr_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    assign fix_quo = (sgn_q && qsign_q) ? -step_quo : step_quo;
    assign fix_rem = (sgn_q && rsign_q) ? -step_rem : step_rem;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        sgn_d    = sgn_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        result_d = result_q;

        case (state_q)
            DIV_IDLE: begin
                if (dif.startE) begin
                    state_d = DIV_BUSY;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = magnitude(dif.srcaE, dif.signedE);
                    dvsr_d  = magnitude(dif.srcbE, dif.signedE);
                    sgn_d   = dif.signedE;
                    qsign_d = dif.srcaE[WIDTH-1] ^ dif.srcbE[WIDTH-1];
                    rsign_d = dif.srcaE[WIDTH-1];
                end
            end
            DIV_BUSY: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                // Result is registered on the final step so it is valid throughout DONE.
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d  = DIV_DONE;
                    result_d = {fix_rem, fix_quo};
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase

        if (dif.annulE) begin
            state_d  = DIV_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            sgn_q    <= 1'b0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            sgn_q    <= sgn_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            result_q <= result_d;
        end
    end

    assign kill            = dif.annulE | rst;
    assign dif.div_stallE  = ~kill & (((state_q == DIV_IDLE) & dif.startE) |
                                      (state_q == DIV_BUSY));
    assign dif.div_readyE  = ~kill & (state_q == DIV_DONE);
    assign dif.div_resultE = result_q;

endmodule
`default_nettype wire
